// File: rtl/gpio_seq.sv
// rtl/gpio_seq.sv - APB-driven GPIO command sequencer (optional irq via GPIO_SEQ_IRQ_EN)
module gpio_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int N_GPIO     = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    output logic        apbm_psel,
    output logic        apbm_penable,
    output logic        apbm_pwrite,
    output logic [15:0] apbm_paddr,
    output logic [31:0] apbm_pwdata,
    input  logic        apbm_pready,
    input  logic        apbm_pslverr,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [31:0]       head;
    logic              en, irq_en, ovf, slverr, done, done_nxt;
    logic [1:0]        cur_op;
    logic [N_GPIO-1:0] cur_data;
    logic [15:0]       cur_delay, dly_cnt;
    logic              wr_acc, wr_ctrl, wr_status, wr_cmd, flush;
    logic              empty, full, pop, push_ok, ovf_set, xfer_done, enter_idle, xfer;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;

    assign wr_acc    = apbs_psel & apbs_penable & apbs_pwrite;
    assign wr_ctrl   = wr_acc && (apbs_paddr == 16'h0000);
    assign wr_status = wr_acc && (apbs_paddr == 16'h0004);
    assign wr_cmd    = wr_acc && (apbs_paddr == 16'h0008);
    assign flush     = wr_ctrl & apbs_pwdata[1];

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = (state == S_IDLE) && en && !empty;
    // A full FIFO still takes the word if a slot frees up in the same cycle
    assign push_ok = wr_cmd && (!full || pop || flush);
    assign ovf_set = wr_cmd && !push_ok;
    assign head    = mem[rd_ptr];
    assign unused_bits = ^head[29:16+N_GPIO];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= apbs_pwdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(push_ok);
            count  <= CW'(push_ok);
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    assign xfer_done = (state == S_ACCESS) && apbm_pready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (en && !empty) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (apbm_pready) state_nxt = (cur_delay == 16'd0) ? S_IDLE : S_WAIT;
            S_WAIT:   if (dly_cnt <= 16'd1) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_op    <= '0;
            cur_data  <= '0;
            cur_delay <= '0;
            dly_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur_op    <= head[31:30];
                cur_data  <= head[16 +: N_GPIO];
                cur_delay <= head[15:0];
            end
            if (xfer_done)            dly_cnt <= cur_delay;
            else if (state == S_WAIT) dly_cnt <= dly_cnt - 16'd1;
        end
    end

    assign xfer         = (state == S_SETUP) || (state == S_ACCESS);
    assign apbm_psel    = xfer;
    assign apbm_penable = (state == S_ACCESS);
    assign apbm_pwrite  = xfer;
    assign apbm_paddr   = xfer ? {12'd0, cur_op, 2'b00} : 16'd0;
    assign apbm_pwdata  = xfer ? {{(32-N_GPIO){1'b0}}, cur_data} : 32'd0;

    assign enter_idle = (state != S_IDLE) && (state_nxt == S_IDLE);
    assign done_nxt   = (done & ~(wr_status & apbs_pwdata[13])) | (enter_idle & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            ovf    <= 1'b0;
            slverr <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr_ctrl) en <= apbs_pwdata[0];
            ovf    <= (ovf & ~(wr_status & apbs_pwdata[11])) | ovf_set;
            slverr <= (slverr & ~(wr_status & apbs_pwdata[12])) | (xfer_done & apbm_pslverr);
            done   <= done_nxt;
        end
    end

`ifdef GPIO_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= apbs_pwdata[2];
            irq <= done_nxt & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (apbs_paddr)
            16'h0000: rd_mux = {29'd0, irq_en, 1'b0, en};
            16'h0004: rd_mux = {18'd0, done, slverr, ovf, empty, full, (state != S_IDLE), 3'd0, 5'(count)};
            default:  rd_mux = 32'd0;
        endcase
    end

    // Read data is captured in the setup phase so it is stable for the access phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          apbs_prdata <= 32'd0;
        else if (apbs_psel && !apbs_penable) apbs_prdata <= rd_mux;
        else if (!apbs_psel)                 apbs_prdata <= 32'd0;
    end
endmodule
